// File: rtl/skew_monitor_ctrl.sv
// Measures rising-edge skew, in clk cycles, between two clk-synchronous
// strobes and flags results that exceed SKEW_LIMIT or time out.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : pulse, arms a measurement from IDLE
//   abort        : return to IDLE from any state, no result
//   cont         : re-arm automatically after each result
//   sig_a, sig_b : monitored strobes, synchronous to clk
//   clr_cnt      : synchronous clear of viol_count
//   busy         : high while ARMED, WAIT or DONE
//   res_valid    : one-cycle pulse when the result fields update
//   res_skew     : measured skew in cycles
//   res_lead     : 0 = A led or tie, 1 = B led
//   res_viol     : result exceeds SKEW_LIMIT or timed out
//   res_timeout  : trailing edge never arrived
//   viol_count   : saturating count of violating results
module skew_monitor_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SKEW_LIMIT = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic             sig_a,
    input  logic             sig_b,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_skew,
    output logic             res_lead,
    output logic             res_viol,
    output logic             res_timeout,
    output logic [CNT_W-1:0] viol_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sig_a_q, sig_b_q;
    logic               rise_a, rise_b;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Which strobe led in the current measurement; kept apart from res_lead
    // so the published result is untouched until the next DONE entry.
    logic               lead_q, lead_d;
    logic               done_entry;
    logic [CNT_W-1:0]   skew_d;
    logic               res_lead_d;
    logic               timeout_d;
    logic               viol_d;

    assign rise_a = sig_a & ~sig_a_q;
    assign rise_b = sig_b & ~sig_b_q;

    // State, counter and edge-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sig_a_q <= 1'b0;
            sig_b_q <= 1'b0;
            cnt_q   <= '0;
            lead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_a_q <= sig_a;
            sig_b_q <= sig_b;
            cnt_q   <= cnt_d;
            lead_q  <= lead_d;
        end
    end

    // Next-state and result computation; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lead_d     = lead_q;
        done_entry = 1'b0;
        skew_d     = '0;
        res_lead_d = lead_q;
        timeout_d  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (rise_a && rise_b) begin
                        done_entry = 1'b1;
                        skew_d     = '0;
                        res_lead_d = 1'b0;
                        lead_d     = 1'b0;
                        state_d    = S_DONE;
                    end else if (rise_a || rise_b) begin
                        lead_d  = rise_b;
                        cnt_d   = CNT_W'(1);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An arrival in the timeout cycle still counts as an arrival
                    if (lead_q ? rise_a : rise_b) begin
                        done_entry = 1'b1;
                        skew_d     = cnt_q;
                        res_lead_d = lead_q;
                        state_d    = S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        done_entry = 1'b1;
                        skew_d     = CNT_W'(TIMEOUT);
                        res_lead_d = lead_q;
                        timeout_d  = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    cnt_d   = '0;
                    state_d = cont ? S_ARMED : S_IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end

        viol_d = timeout_d | (skew_d > CNT_W'(SKEW_LIMIT));
    end

    // Registered outputs; result fields load only on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_skew    <= '0;
            res_lead    <= 1'b0;
            res_viol    <= 1'b0;
            res_timeout <= 1'b0;
            viol_count  <= '0;
        end else begin
            busy      <= (state_d != S_IDLE);
            res_valid <= done_entry;
            if (done_entry) begin
                res_skew    <= skew_d;
                res_lead    <= res_lead_d;
                res_viol    <= viol_d;
                res_timeout <= timeout_d;
            end
            // Clear beats a coincident increment; count saturates at all-ones
            if (clr_cnt) begin
                viol_count <= '0;
            end else if (done_entry && viol_d && (viol_count != '1)) begin
                viol_count <= viol_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_skew_monitor_ctrl.sv
// Self-checking bench for skew_monitor_ctrl: a timestamp-based reference
// model checked every cycle, plus literal expectations per scenario.
module tb_skew_monitor_ctrl;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned SKEW_LIMIT = 2;
    localparam int unsigned TIMEOUT    = 255;
    localparam int          VC_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cont = 1'b0;
    logic             sig_a = 1'b0;
    logic             sig_b = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             busy;
    logic             res_valid;
    logic [CNT_W-1:0] res_skew;
    logic             res_lead;
    logic             res_viol;
    logic             res_timeout;
    logic [CNT_W-1:0] viol_count;

    int n_cmp = 0;
    int n_bad = 0;

    skew_monitor_ctrl #(
        .CNT_W      (CNT_W),
        .SKEW_LIMIT (SKEW_LIMIT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cont        (cont),
        .sig_a       (sig_a),
        .sig_b       (sig_b),
        .clr_cnt     (clr_cnt),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_skew    (res_skew),
        .res_lead    (res_lead),
        .res_viol    (res_viol),
        .res_timeout (res_timeout),
        .viol_count  (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phases plus a cycle timestamp of the leading edge;
    // skew is the difference of timestamps.
    int e_busy, e_valid, e_skew, e_lead, e_viol, e_to, e_vc;

    always @(posedge clk or negedge rst_n) begin : model
        int ph, tl, cyc, vc, sk;
        bit lb, pa, pb, ra, rb, to, vi, fin;
        if (!rst_n) begin
            ph = 0; tl = 0; cyc = 0; vc = 0; lb = 0; pa = 0; pb = 0;
            e_busy <= 0; e_valid <= 0; e_skew <= 0; e_lead <= 0;
            e_viol <= 0; e_to <= 0; e_vc <= 0;
        end else begin
            ra = sig_a && !pa;
            rb = sig_b && !pb;
            pa = sig_a;
            pb = sig_b;
            fin = 0; sk = 0; to = 0; vi = 0;
            if (abort) begin
                ph = 0;
            end else begin
                case (ph)
                    0: if (start) ph = 1;
                    1: begin
                        if (ra && rb) begin
                            fin = 1; sk = 0; lb = 0;
                        end else if (ra || rb) begin
                            lb = rb; tl = cyc; ph = 2;
                        end
                    end
                    2: begin
                        if (lb ? ra : rb) begin
                            fin = 1; sk = cyc - tl;
                        end else if (cyc - tl == int'(TIMEOUT)) begin
                            fin = 1; sk = int'(TIMEOUT); to = 1;
                        end
                    end
                    default: ph = cont ? 1 : 0;
                endcase
            end
            if (fin) begin
                ph = 3;
                vi = to || (sk > int'(SKEW_LIMIT));
                if (vi && vc < VC_MAX) vc++;
                e_skew <= sk; e_lead <= int'(lb); e_to <= int'(to); e_viol <= int'(vi);
            end
            if (clr_cnt) vc = 0;
            e_valid <= int'(fin);
            e_busy  <= int'(ph != 0);
            e_vc    <= vc;
            cyc++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",        int'(busy),        e_busy);
            chk("res_valid",   int'(res_valid),   e_valid);
            chk("res_skew",    int'(res_skew),    e_skew);
            chk("res_lead",    int'(res_lead),    e_lead);
            chk("res_viol",    int'(res_viol),    e_viol);
            chk("res_timeout", int'(res_timeout), e_to);
            chk("viol_count",  int'(viol_count),  e_vc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Counts negedges until res_valid is seen; an expired budget is a failure
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (res_valid !== 1'b1 && n < budget);
        if (res_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: no res_valid within %0d cycles", n);
        end
    endtask

    // A-leads measurement with skew 3: always a violation
    task automatic violation(input bit clr);
        int n;
        pulse_start();
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        step(2);
        sig_b = 1'b1;
        clr_cnt = clr;
        wait_valid(20, n);
        sig_b = 1'b0;
        clr_cnt = 1'b0;
        step(1);
    endtask

    initial begin
        int n;
        step(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_vc", int'(viol_count), 0);
        rst_n = 1'b1;
        step(1);

        // 1: A then B one cycle later
        pulse_start();
        step(6);
        sig_a = 1'b1;
        step(1);
        sig_b = 1'b1;
        wait_valid(20, n);
        chk("t1_latency", n, 1);
        chk("t1_skew", int'(res_skew), 1);
        chk("t1_lead", int'(res_lead), 0);
        chk("t1_viol", int'(res_viol), 0);
        chk("t1_timeout", int'(res_timeout), 0);
        chk("t1_vc", int'(viol_count), 0);
        sig_a = 1'b0;
        sig_b = 1'b0;
        step(1);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: B leads by 4, second B pulse mid-WAIT ignored
        pulse_start();
        sig_b = 1'b1;
        step(1);
        sig_b = 1'b0;
        step(1);
        sig_b = 1'b1;
        step(1);
        sig_b = 1'b0;
        step(1);
        sig_a = 1'b1;
        wait_valid(20, n);
        chk("t2_skew", int'(res_skew), 4);
        chk("t2_lead", int'(res_lead), 1);
        chk("t2_viol", int'(res_viol), 1);
        chk("t2_vc", int'(viol_count), 1);
        sig_a = 1'b0;
        step(1);

        // 3a: simultaneous rise
        pulse_start();
        sig_a = 1'b1;
        sig_b = 1'b1;
        wait_valid(20, n);
        chk("t3_tie_skew", int'(res_skew), 0);
        chk("t3_tie_lead", int'(res_lead), 0);
        chk("t3_tie_viol", int'(res_viol), 0);
        sig_a = 1'b0;
        sig_b = 1'b0;
        step(1);

        // 3b: B never arrives
        pulse_start();
        sig_a = 1'b1;
        wait_valid(400, n);
        chk("t3_to_latency", n, 256);
        chk("t3_to_skew", int'(res_skew), 255);
        chk("t3_to_timeout", int'(res_timeout), 1);
        chk("t3_to_viol", int'(res_viol), 1);
        chk("t3_to_vc", int'(viol_count), 2);
        sig_a = 1'b0;
        step(1);

        // 4: continuous mode, skews 1, 3, 2
        cont = 1'b1;
        pulse_start();
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        sig_b = 1'b1;
        wait_valid(20, n);
        chk("t4_p1_skew", int'(res_skew), 1);
        chk("t4_p1_viol", int'(res_viol), 0);
        sig_b = 1'b0;
        step(1);
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        step(2);
        sig_b = 1'b1;
        wait_valid(20, n);
        chk("t4_p2_skew", int'(res_skew), 3);
        chk("t4_p2_viol", int'(res_viol), 1);
        chk("t4_p2_busy", int'(busy), 1);
        sig_b = 1'b0;
        step(1);
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        step(1);
        sig_b = 1'b1;
        cont = 1'b0;
        wait_valid(20, n);
        chk("t4_p3_skew", int'(res_skew), 2);
        chk("t4_p3_viol", int'(res_viol), 0);
        chk("t4_vc", int'(viol_count), 3);
        sig_b = 1'b0;
        step(1);
        chk("t4_end_busy", int'(busy), 0);

        // 5a: abort in WAIT keeps the previous result
        pulse_start();
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_valid", int'(res_valid), 0);
        chk("t5_abort_skew", int'(res_skew), 2);
        sig_b = 1'b1;
        step(3);
        sig_b = 1'b0;
        chk("t5_abort_novalid", int'(res_valid), 0);
        step(1);

        // 5b: asynchronous reset mid-WAIT
        pulse_start();
        sig_a = 1'b1;
        step(1);
        sig_a = 1'b0;
        step(2);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_skew", int'(res_skew), 0);
        chk("t5_rst_viol", int'(res_viol), 0);
        chk("t5_rst_vc", int'(viol_count), 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // 6: saturation and clear-beats-increment
        for (int i = 1; i <= 256; i++) begin
            violation(1'b0);
            if (i == 255) chk("t6_vc_255", int'(viol_count), 255);
        end
        chk("t6_vc_sat", int'(viol_count), 255);
        violation(1'b1);
        chk("t6_clr_vc", int'(viol_count), 0);
        chk("t6_clr_viol", int'(res_viol), 1);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
